// File: rtl/bitlet_esum_align_buf.sv
// Esum buffer and alignment-shift stage: holds one group of Esum vectors until E.max arrives,
// then replays per-lane shifts (Emax - Esum, saturated). Optional: BITLET_ALIGN_SAT_FLAG_EN.
module bitlet_esum_align_buf #(
    parameter int unsigned N_input = 16,
    parameter int unsigned P_input = 4,
    parameter int unsigned W_E     = 10,
    parameter int unsigned W_S     = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         Esum_vld,
    input  logic [N_input*W_E-1:0]       Esum_vec,
    output logic                         in_rdy,
    input  logic                         Emax_vld,
    input  logic [W_E-1:0]               Emax,
    output logic                         Sft_vld,
    output logic [N_input*W_S-1:0]       Sft_vec,
    output logic [$clog2(P_input)-1:0]   Sft_idx,
    output logic                         Sft_last,
    output logic                         err
`ifdef BITLET_ALIGN_SAT_FLAG_EN
    ,
    output logic [N_input-1:0]           Sft_sat
`endif
);

    localparam int unsigned IW = $clog2(P_input);
    localparam logic [IW-1:0] LastIdx = IW'(P_input - 1);
    localparam logic [W_E:0] SatMax = (W_E + 1)'((1 << W_S) - 1);

    typedef enum logic [1:0] {StFill, StWait, StDrain} state_e;

    state_e                     state_q, state_d;
    logic [IW-1:0]              wr_cnt_q, wr_cnt_d;
    logic [IW-1:0]              rd_cnt_q, rd_cnt_d;
    logic [W_E-1:0]             emax_q, emax_d;
    logic                       sft_vld_q, sft_vld_d;
    logic [N_input*W_S-1:0]     sft_vec_q, sft_vec_d;
    logic [IW-1:0]              sft_idx_q, sft_idx_d;
    logic                       sft_last_q, sft_last_d;
    logic                       err_q, err_d;
    logic [N_input*W_E-1:0]     mem_q [P_input];

    logic                       wr_en;
    logic                       load_beat;
    logic [W_E-1:0]             sel_emax;
    logic [N_input*W_E-1:0]     sel_vec;
    logic [W_E:0]               diff;
    logic [N_input*W_S-1:0]     lane_sft;
    logic [N_input-1:0]         lane_neg;
`ifdef BITLET_ALIGN_SAT_FLAG_EN
    logic [N_input-1:0]         lane_sat;
    logic [N_input-1:0]         sft_sat_q, sft_sat_d;
`endif

    // rd_cnt is 0 in WAIT, so the first beat can be computed straight from the incoming Emax.
    always_comb begin
        sel_vec  = mem_q[rd_cnt_q];
        sel_emax = (state_q == StWait) ? Emax : emax_q;
        diff     = '0;
        lane_sft = '0;
        lane_neg = '0;
`ifdef BITLET_ALIGN_SAT_FLAG_EN
        lane_sat = '0;
`endif
        for (int i = 0; i < int'(N_input); i++) begin
            diff = {1'b0, sel_emax} - {1'b0, sel_vec[i*W_E +: W_E]};
            if (diff[W_E]) begin
                lane_neg[i] = 1'b1;
            end else if (diff > SatMax) begin
                lane_sft[i*W_S +: W_S] = '1;
`ifdef BITLET_ALIGN_SAT_FLAG_EN
                lane_sat[i] = 1'b1;
`endif
            end else begin
                lane_sft[i*W_S +: W_S] = diff[W_S-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        emax_d     = emax_q;
        sft_vld_d  = 1'b0;
        sft_vec_d  = sft_vec_q;
        sft_idx_d  = sft_idx_q;
        sft_last_d = sft_last_q;
        err_d      = err_q;
        wr_en      = 1'b0;
        load_beat  = 1'b0;
`ifdef BITLET_ALIGN_SAT_FLAG_EN
        sft_sat_d  = sft_sat_q;
`endif
        if (flush) begin
            state_d    = StFill;
            wr_cnt_d   = '0;
            rd_cnt_d   = '0;
            sft_last_d = 1'b0;
            err_d      = 1'b0;
`ifdef BITLET_ALIGN_SAT_FLAG_EN
            sft_sat_d  = '0;
`endif
        end else begin
            unique case (state_q)
                StFill: begin
                    if (Emax_vld) err_d = 1'b1;
                    if (Esum_vld) begin
                        wr_en    = 1'b1;
                        wr_cnt_d = wr_cnt_q + 1'b1;
                        if (wr_cnt_q == LastIdx) begin
                            wr_cnt_d = '0;
                            state_d  = StWait;
                        end
                    end
                end
                StWait: begin
                    if (Esum_vld) err_d = 1'b1;
                    if (Emax_vld) begin
                        emax_d    = Emax;
                        load_beat = 1'b1;
                        rd_cnt_d  = rd_cnt_q + 1'b1;
                        state_d   = StDrain;
                    end
                end
                StDrain: begin
                    if (Esum_vld || Emax_vld) err_d = 1'b1;
                    // rd_cnt back at 0 means the last beat is already on the output.
                    if (rd_cnt_q == '0) begin
                        state_d = StFill;
                    end else begin
                        load_beat = 1'b1;
                        rd_cnt_d  = rd_cnt_q + 1'b1;
                    end
                end
                default: state_d = StFill;
            endcase

            if (load_beat) begin
                sft_vld_d  = 1'b1;
                sft_vec_d  = lane_sft;
                sft_idx_d  = rd_cnt_q;
                sft_last_d = (rd_cnt_q == LastIdx);
                if (|lane_neg) err_d = 1'b1;
`ifdef BITLET_ALIGN_SAT_FLAG_EN
                sft_sat_d  = lane_sat;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFill;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            emax_q     <= '0;
            sft_vld_q  <= 1'b0;
            sft_vec_q  <= '0;
            sft_idx_q  <= '0;
            sft_last_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef BITLET_ALIGN_SAT_FLAG_EN
            sft_sat_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            emax_q     <= emax_d;
            sft_vld_q  <= sft_vld_d;
            sft_vec_q  <= sft_vec_d;
            sft_idx_q  <= sft_idx_d;
            sft_last_q <= sft_last_d;
            err_q      <= err_d;
`ifdef BITLET_ALIGN_SAT_FLAG_EN
            sft_sat_q  <= sft_sat_d;
`endif
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_cnt_q] <= Esum_vec;
    end

    assign in_rdy   = (state_q == StFill);
    assign Sft_vld  = sft_vld_q;
    assign Sft_vec  = sft_vec_q;
    assign Sft_idx  = sft_idx_q;
    assign Sft_last = sft_last_q;
    assign err      = err_q;
`ifdef BITLET_ALIGN_SAT_FLAG_EN
    assign Sft_sat  = sft_sat_q;
`endif

endmodule

// File: tb/tb_bitlet_esum_align_buf.sv
// Scoreboard bench for bitlet_esum_align_buf (N_input=16, P_input=4, W_E=10, W_S=5).
module tb_bitlet_esum_align_buf;

    localparam int N = 16;
    localparam int P = 4;
    localparam int WE = 10;
    localparam int WS = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              Esum_vld = 1'b0;
    logic [N*WE-1:0]   Esum_vec = '0;
    logic              in_rdy;
    logic              Emax_vld = 1'b0;
    logic [WE-1:0]     Emax = '0;
    logic              Sft_vld;
    logic [N*WS-1:0]   Sft_vec;
    logic [1:0]        Sft_idx;
    logic              Sft_last;
    logic              err;
`ifdef BITLET_ALIGN_SAT_FLAG_EN
    logic [N-1:0]      Sft_sat;
`endif

    bitlet_esum_align_buf #(.N_input(N), .P_input(P), .W_E(WE), .W_S(WS)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .Esum_vld (Esum_vld),
        .Esum_vec (Esum_vec),
        .in_rdy   (in_rdy),
        .Emax_vld (Emax_vld),
        .Emax     (Emax),
        .Sft_vld  (Sft_vld),
        .Sft_vec  (Sft_vec),
        .Sft_idx  (Sft_idx),
        .Sft_last (Sft_last),
        .err      (err)
`ifdef BITLET_ALIGN_SAT_FLAG_EN
        ,
        .Sft_sat  (Sft_sat)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int n_out = 0;

    logic [N*WE-1:0] grp [P];
    logic [N*WS-1:0] exp_vec_q [$];
    logic [1:0]      exp_idx_q [$];
    logic            exp_last_q [$];
    logic [N-1:0]    exp_sat_q [$];

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && Sft_vld) begin
            n_out++;
            if (exp_vec_q.size() == 0) begin
                check_val("unexpected_vld", 1, 0);
            end else begin
                check_val("sft_vec", Sft_vec, exp_vec_q.pop_front());
                check_val("sft_idx", Sft_idx, exp_idx_q.pop_front());
                check_val("sft_last", Sft_last, exp_last_q.pop_front());
`ifdef BITLET_ALIGN_SAT_FLAG_EN
                check_val("sft_sat", Sft_sat, exp_sat_q.pop_front());
`else
                void'(exp_sat_q.pop_front());
`endif
            end
        end
    end

    function automatic logic [N*WE-1:0] all_lanes(input int val);
        logic [N*WE-1:0] v;
        for (int i = 0; i < N; i++) v[i*WE +: WE] = WE'(val);
        return v;
    endfunction

    // Push expected beats 0..cnt-1 of the current group for the given Emax.
    task automatic push_group(input int emax, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            logic [N*WS-1:0] sv;
            logic [N-1:0]    st;
            sv = '0;
            st = '0;
            for (int i = 0; i < N; i++) begin
                int e;
                int d;
                e = grp[k][i*WE +: WE];
                d = emax - e;
                if (d < 0) sv[i*WS +: WS] = '0;
                else if (d > 31) begin
                    sv[i*WS +: WS] = WS'(31);
                    st[i] = 1'b1;
                end else sv[i*WS +: WS] = WS'(d);
            end
            exp_vec_q.push_back(sv);
            exp_idx_q.push_back(2'(k));
            exp_last_q.push_back(k == P - 1);
            exp_sat_q.push_back(st);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [N*WE-1:0] v);
        Esum_vld = 1'b1;
        Esum_vec = v;
        @(posedge clk);
        #1;
        Esum_vld = 1'b0;
    endtask

    task automatic send_group();
        for (int k = 0; k < P; k++) send_beat(grp[k]);
        @(negedge clk);
        check_val("in_rdy_wait", in_rdy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // Emax pulse then P contiguous output beats; optional junk Esum beat during drain.
    task automatic run_drain(input int emax, input bit poke);
        push_group(emax, P);
        Emax_vld = 1'b1;
        Emax = WE'(emax);
        @(posedge clk);
        #1;
        Emax_vld = 1'b0;
        for (int k = 0; k < P; k++) begin
            if (poke && k == 1) begin
                Esum_vld = 1'b1;
                Esum_vec = all_lanes(999);
            end
            @(negedge clk);
            check_val("drain_vld", Sft_vld, 1);
            check_val("drain_in_rdy", in_rdy, 0);
            @(posedge clk);
            #1;
            Esum_vld = 1'b0;
        end
        @(negedge clk);
        check_val("post_drain_vld", Sft_vld, 0);
        check_val("post_drain_in_rdy", in_rdy, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int snap;
        #2;
        check_val("rst_in_rdy", in_rdy, 1);
        check_val("rst_vld", Sft_vld, 0);
        check_val("rst_vec", Sft_vec, 0);
        check_val("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Basic group
        for (int k = 0; k < P; k++) grp[k] = all_lanes(100 + k);
        send_group();
        run_drain(103, 1'b0);
        check_val("basic_err", err, 0);

        // Saturation
        for (int k = 0; k < P; k++) begin
            grp[k] = all_lanes(60);
            grp[k][0*WE +: WE] = WE'(10);
            grp[k][1*WE +: WE] = WE'(40);
        end
        send_group();
        run_drain(60, 1'b0);
        check_val("sat_err", err, 0);

        // Underflow: err sticky until flush
        for (int k = 0; k < P; k++) begin
            grp[k] = all_lanes(50 + k);
            grp[k][5*WE +: WE] = WE'(70);
        end
        send_group();
        run_drain(60, 1'b0);
        check_val("under_err", err, 1);
        idle(3);
        check_val("under_err_held", err, 1);
        do_flush();
        check_val("under_err_flushed", err, 0);

        // Protocol: drops in WAIT and DRAIN leave buffered data intact
        for (int k = 0; k < P; k++) begin
            for (int i = 0; i < N; i++) grp[k][i*WE +: WE] = WE'($urandom_range(500));
        end
        send_group();
        send_beat(all_lanes(7));
        check_val("wait_drop_err", err, 1);
        check_val("wait_in_rdy", in_rdy, 0);
        run_drain(520, 1'b1);
        check_val("drain_drop_err", err, 1);
        do_flush();
        check_val("proto_flush_err", err, 0);
        Emax_vld = 1'b1;
        Emax = WE'(300);
        @(posedge clk);
        #1;
        Emax_vld = 1'b0;
        @(negedge clk);
        check_val("fill_emax_err", err, 1);
        check_val("fill_emax_vld", Sft_vld, 0);
        check_val("fill_emax_in_rdy", in_rdy, 1);
        @(posedge clk);
        #1;
        do_flush();

        // Flush on the 2nd drain beat
        for (int k = 0; k < P; k++) grp[k] = all_lanes(200 + 3 * k);
        grp[0][2*WE +: WE] = WE'(900);
        send_group();
        push_group(215, 2);
        Emax_vld = 1'b1;
        Emax = WE'(215);
        @(posedge clk);
        #1;
        Emax_vld = 1'b0;
        @(posedge clk);
        #1;
        check_val("pre_flush_err", err, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_val("flush_vld", Sft_vld, 0);
        check_val("flush_in_rdy", in_rdy, 1);
        check_val("flush_err", err, 0);
        check_val("flush_last", Sft_last, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < P; k++) grp[k] = all_lanes(300 - 5 * k);
        send_group();
        run_drain(310, 1'b0);

        // Asynchronous reset mid-fill
        send_beat(all_lanes(11));
        send_beat(all_lanes(12));
        #3;
        rst = 1'b1;
        #2;
        check_val("arst_in_rdy", in_rdy, 1);
        check_val("arst_vld", Sft_vld, 0);
        check_val("arst_vec", Sft_vec, 0);
        check_val("arst_idx", Sft_idx, 0);
        check_val("arst_last", Sft_last, 0);
        check_val("arst_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        snap = n_out;
        for (int k = 0; k < P; k++) grp[k] = all_lanes(400 + k);
        send_group();
        run_drain(420, 1'b0);
        idle(4);
        check_val("arst_out_count", n_out - snap, P);
        check_val("sb_empty", exp_vec_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
